// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port, fixed-latency SRAM between the instruction-fetch (IF)
// stage and the load/store (MEM) stage of the 5-stage pipeline. One requester
// is granted at a time. The grant is followed by WAIT_CYCLES access cycles and
// then a single DONE cycle in which the owner's ready pulse is raised.
//
// Handshake: a requester raises its request (if_req, or mem_rd_en/mem_wr_en)
// and holds it, with stable address/data, until its ready pulse. The ready
// pulse is high for exactly one cycle, and the matching rdata is valid in that
// cycle. Rdata then holds until the next capture for that requester. Requests
// are sampled only in IDLE. A request seen in ACCESS/DONE waits, and its stall
// stays high until it is served.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   if_req        IF read request
//   if_addr       IF byte address
//   mem_rd_en     MEM load request
//   mem_wr_en     MEM store request (wins over mem_rd_en)
//   mem_addr      MEM byte address
//   mem_wdata     MEM store data
//   if_rdata      fetched word, valid with if_ready
//   if_ready      one-cycle done pulse for IF
//   mem_rdata     loaded word, valid with mem_ready
//   mem_ready     one-cycle done pulse for MEM
//   if_stall      if_req & ~if_ready
//   mem_stall     (mem_rd_en | mem_wr_en) & ~mem_ready
//   sram_addr     SRAM word address
//   sram_wdata    SRAM write data
//   sram_we_n     SRAM write enable, active-low
//   sram_rdata    SRAM read data, valid in the final ACCESS cycle
//   dbg_state     current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SRAM_AW     = 17,
  parameter int WAIT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  input  logic               mem_rd_en,
  input  logic               mem_wr_en,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_wdata,
  output logic [DATA_W-1:0]  if_rdata,
  output logic               if_ready,
  output logic [DATA_W-1:0]  mem_rdata,
  output logic               mem_ready,
  output logic               if_stall,
  output logic               mem_stall,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DATA_W-1:0]  sram_wdata,
  output logic               sram_we_n,
  input  logic [DATA_W-1:0]  sram_rdata,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t             state, state_n;
  logic [3:0]         cnt, cnt_n;
  logic               grant;
  logic               capture;

  // Transfer context latched at grant; the requester's inputs are not looked
  // at again until the transfer finishes.
  logic               owner_mem;
  logic               op_wr;
  logic [SRAM_AW-1:0] addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  if_rdata_q;
  logic [DATA_W-1:0]  mem_rdata_q;

  logic               mem_req;

  // Byte-offset bits and address bits above the SRAM window do not select
  // a word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], if_addr[ADDR_W-1:SRAM_AW+2],
                              mem_addr[1:0], mem_addr[ADDR_W-1:SRAM_AW+2]};

  assign mem_req = mem_rd_en | mem_wr_en;

  // ---------------------------------------------------------------------------
  // Next-state / control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    grant   = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req || if_req) begin
          grant   = 1'b1;
          cnt_n   = CNT_LOAD;
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          capture = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      DONE: begin
        // The mandatory return to IDLE leaves one idle cycle between grants.
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      owner_mem   <= 1'b0;
      op_wr       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (grant) begin
        // MEM has fixed priority. Its instruction is older in the pipe. A
        // simultaneous read+write is a store.
        owner_mem <= mem_req;
        op_wr     <= mem_req & mem_wr_en;
        addr_q    <= mem_req ? mem_addr[SRAM_AW+1:2] : if_addr[SRAM_AW+1:2];
        wdata_q   <= mem_wdata;
      end
      if (capture) begin
        if (!owner_mem) begin
          if_rdata_q <= sram_rdata;
        end else if (!op_wr) begin
          mem_rdata_q <= sram_rdata;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign if_ready   = (state == DONE) && !owner_mem;
  assign mem_ready  = (state == DONE) &&  owner_mem;
  assign if_rdata   = if_rdata_q;
  assign mem_rdata  = mem_rdata_q;

  assign if_stall   = if_req  & ~if_ready;
  assign mem_stall  = mem_req & ~mem_ready;

  // Write strobe is derived from state. A reset therefore releases it at the
  // same edge that returns the FSM to IDLE.
  assign sram_we_n  = !((state == ACCESS) && op_wr);
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

  assign dbg_state  = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Two arbiters share clock and reset: dut4 (WAIT_CYCLES=4) and dut1
// (WAIT_CYCLES=1). Each one drives its own behavioural SRAM, which has a
// combinational read and writes on posedge while sram_we_n is low.
//
// Each table vector covers one clock cycle of dut4. The inputs are applied
// just after posedge, and the outputs are compared at the following negedge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  // dut4 signals
  logic        if_req, mem_rd_en, mem_wr_en;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata, mem_rdata, sram_wdata, sram_rdata;
  logic        if_ready, mem_ready, if_stall, mem_stall, sram_we_n;
  logic [16:0] sram_addr;
  logic [1:0]  dbg_state;

  // dut1 signals
  logic        b_if_req, b_mem_rd_en, b_mem_wr_en;
  logic [31:0] b_if_addr, b_mem_addr, b_mem_wdata;
  logic [31:0] b_if_rdata, b_mem_rdata, b_sram_wdata, b_sram_rdata;
  logic        b_if_ready, b_mem_ready, b_if_stall, b_mem_stall, b_sram_we_n;
  logic [16:0] b_sram_addr;
  logic [1:0]  b_dbg_state;

  mem_arbiter #(.WAIT_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .if_stall(if_stall), .mem_stall(mem_stall),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_we_n(sram_we_n), .sram_rdata(sram_rdata),
    .dbg_state(dbg_state)
  );

  mem_arbiter #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr),
    .mem_rd_en(b_mem_rd_en), .mem_wr_en(b_mem_wr_en),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready),
    .if_stall(b_if_stall), .mem_stall(b_mem_stall),
    .sram_addr(b_sram_addr), .sram_wdata(b_sram_wdata),
    .sram_we_n(b_sram_we_n), .sram_rdata(b_sram_rdata),
    .dbg_state(b_dbg_state)
  );

  // Behavioural SRAMs
  logic [31:0] mem4 [0:255];
  logic [31:0] mem1 [0:255];
  assign sram_rdata   = mem4[sram_addr[7:0]];
  assign b_sram_rdata = mem1[b_sram_addr[7:0]];
  always @(posedge clk) begin
    if (!sram_we_n)   mem4[sram_addr[7:0]]   <= sram_wdata;
    if (!b_sram_we_n) mem1[b_sram_addr[7:0]] <= b_sram_wdata;
  end

  // Vector table
  typedef struct {
    logic        ifq;
    logic [31:0] ifa;
    logic        rd, wr;
    logic [31:0] ma, wd;
    logic        e_ifr, e_mr, e_ist, e_mst, e_wen;
    logic [16:0] e_sa;
    logic [31:0] e_ifd, e_md;
  } vec_t;

  vec_t vq[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cur    = 0;

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] CF = 32'hCAFEF00D;

  task automatic v(input logic ifq, input logic [31:0] ifa,
                   input logic rd, input logic wr,
                   input logic [31:0] ma, input logic [31:0] wd,
                   input logic e_ifr, input logic e_mr,
                   input logic e_ist, input logic e_mst, input logic e_wen,
                   input logic [16:0] e_sa,
                   input logic [31:0] e_ifd, input logic [31:0] e_md);
    vec_t t;
    t.ifq = ifq; t.ifa = ifa; t.rd = rd; t.wr = wr; t.ma = ma; t.wd = wd;
    t.e_ifr = e_ifr; t.e_mr = e_mr; t.e_ist = e_ist; t.e_mst = e_mst;
    t.e_wen = e_wen; t.e_sa = e_sa; t.e_ifd = e_ifd; t.e_md = e_md;
    vq.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, cur, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 0; if_addr = 0; mem_rd_en = 0; mem_wr_en = 0; mem_addr = 0; mem_wdata = 0;
    b_if_req = 0; b_if_addr = 0; b_mem_rd_en = 0; b_mem_wr_en = 0; b_mem_addr = 0;
    b_mem_wdata = 0;
    for (int i = 0; i < 256; i++) begin
      mem4[i] = 32'h0;
      mem1[i] = 32'h0;
    end
    mem4[16] = DB;
    mem4[17] = CF;
    mem1[16] = 32'h13579BDF;

    //  ifq ifa     rd wr ma      wd            ifr mr ist mst wen sa      ifd md
    // reset state
    v(0, 32'h0,  0, 0, 32'h0, 32'h0,        0, 0, 0, 0, 1, 17'h0,  32'h0, 32'h0);
    // IF fetch of 0x40; address changes mid-access must be ignored
    v(1, 32'h40, 0, 0, 32'h0, 32'h0,        0, 0, 1, 0, 1, 17'h0,  32'h0, 32'h0);
    v(1, 32'h40, 0, 0, 32'h0, 32'h0,        0, 0, 1, 0, 1, 17'h10, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++)
      v(1, 32'h80, 0, 0, 32'h0, 32'h0,      0, 0, 1, 0, 1, 17'h10, 32'h0, 32'h0);
    v(1, 32'h80, 0, 0, 32'h0, 32'h0,        1, 0, 0, 0, 1, 17'h10, DB,    32'h0);
    v(0, 32'h0,  0, 0, 32'h0, 32'h0,        0, 0, 0, 0, 1, 17'h10, DB,    32'h0);
    // store 0x1234 to 0x8
    v(0, 32'h0,  0, 1, 32'h8, 32'h1234,     0, 0, 0, 1, 1, 17'h10, DB,    32'h0);
    for (int i = 0; i < 4; i++)
      v(0, 32'h0, 0, 1, 32'h8, 32'h1234,    0, 0, 0, 1, 0, 17'h2,  DB,    32'h0);
    v(0, 32'h0,  0, 1, 32'h8, 32'h1234,     0, 1, 0, 0, 1, 17'h2,  DB,    32'h0);
    // load back from 0x8
    for (int i = 0; i < 5; i++)
      v(0, 32'h0, 1, 0, 32'h8, 32'h0,       0, 0, 0, 1, 1, 17'h2,  DB,    32'h0);
    v(0, 32'h0,  1, 0, 32'h8, 32'h0,        0, 1, 0, 0, 1, 17'h2,  DB,    32'h1234);
    v(0, 32'h0,  0, 0, 32'h0, 32'h0,        0, 0, 0, 0, 1, 17'h2,  DB,    32'h1234);
    // IF and MEM load rise together: MEM first, IF after one idle cycle
    v(1, 32'h44, 1, 0, 32'h40, 32'h0,       0, 0, 1, 1, 1, 17'h2,  DB,    32'h1234);
    for (int i = 0; i < 4; i++)
      v(1, 32'h44, 1, 0, 32'h40, 32'h0,     0, 0, 1, 1, 1, 17'h10, DB,    32'h1234);
    v(1, 32'h44, 1, 0, 32'h40, 32'h0,       0, 1, 1, 0, 1, 17'h10, DB,    DB);
    v(1, 32'h44, 0, 0, 32'h0, 32'h0,        0, 0, 1, 0, 1, 17'h10, DB,    DB);
    for (int i = 0; i < 4; i++)
      v(1, 32'h44, 0, 0, 32'h0, 32'h0,      0, 0, 1, 0, 1, 17'h11, DB,    DB);
    v(1, 32'h44, 0, 0, 32'h0, 32'h0,        1, 0, 0, 0, 1, 17'h11, CF,    DB);
    v(0, 32'h0,  0, 0, 32'h0, 32'h0,        0, 0, 0, 0, 1, 17'h11, CF,    DB);
    // rd+wr together is a store; mem_rdata is untouched
    v(0, 32'h0,  1, 1, 32'hC, 32'h5555AAAA, 0, 0, 0, 1, 1, 17'h11, CF,    DB);
    for (int i = 0; i < 4; i++)
      v(0, 32'h0, 1, 1, 32'hC, 32'h5555AAAA, 0, 0, 0, 1, 0, 17'h3, CF,    DB);
    v(0, 32'h0,  1, 1, 32'hC, 32'h5555AAAA, 0, 1, 0, 0, 1, 17'h3,  CF,    DB);
    v(0, 32'h0,  0, 0, 32'h0, 32'h0,        0, 0, 0, 0, 1, 17'h3,  CF,    DB);
    // load back from 0xC proves the write happened
    for (int i = 0; i < 5; i++)
      v(0, 32'h0, 1, 0, 32'hC, 32'h0,       0, 0, 0, 1, 1, 17'h3,  CF,    DB);
    v(0, 32'h0,  1, 0, 32'hC, 32'h0,        0, 1, 0, 0, 1, 17'h3,  CF,    32'h5555AAAA);
    v(0, 32'h0,  0, 0, 32'h0, 32'h0,        0, 0, 0, 0, 1, 17'h3,  CF,    32'h5555AAAA);

    // clock / reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // table-driven phase
    for (int i = 0; i < vq.size(); i++) begin
      cur       = i;
      if_req    = vq[i].ifq;
      if_addr   = vq[i].ifa;
      mem_rd_en = vq[i].rd;
      mem_wr_en = vq[i].wr;
      mem_addr  = vq[i].ma;
      mem_wdata = vq[i].wd;
      @(negedge clk);
      check("if_ready",  {31'b0, if_ready},  {31'b0, vq[i].e_ifr});
      check("mem_ready", {31'b0, mem_ready}, {31'b0, vq[i].e_mr});
      check("if_stall",  {31'b0, if_stall},  {31'b0, vq[i].e_ist});
      check("mem_stall", {31'b0, mem_stall}, {31'b0, vq[i].e_mst});
      check("sram_we_n", {31'b0, sram_we_n}, {31'b0, vq[i].e_wen});
      check("sram_addr", {15'b0, sram_addr}, {15'b0, vq[i].e_sa});
      check("if_rdata",  if_rdata,  vq[i].e_ifd);
      check("mem_rdata", mem_rdata, vq[i].e_md);
      next_cycle();
    end

    // reset in the 2nd ACCESS cycle of a store aborts it; held request restarts
    cur = 1000;
    mem_wr_en = 1; mem_addr = 32'h20; mem_wdata = 32'h77;
    @(negedge clk); check("rst_seq grant stall", {31'b0, mem_stall}, 32'd1);
    next_cycle();
    @(negedge clk); check("rst_seq access1 we_n", {31'b0, sram_we_n}, 32'd0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk); check("rst_seq access2 we_n", {31'b0, sram_we_n}, 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rst_seq mem_ready",  {31'b0, mem_ready}, 32'd0);
    check("rst_seq we_n",       {31'b0, sram_we_n}, 32'd1);
    check("rst_seq state",      {30'b0, dbg_state}, 32'd0);
    check("rst_seq mem_rdata",  mem_rdata, 32'h0);
    check("rst_seq if_rdata",   if_rdata,  32'h0);
    check("rst_seq mem_stall",  {31'b0, mem_stall}, 32'd1);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      cur = 1010 + i;
      @(negedge clk);
      check("rst_seq fresh we_n",  {31'b0, sram_we_n}, 32'd0);
      check("rst_seq fresh addr",  {15'b0, sram_addr}, 32'h8);
      check("rst_seq fresh ready", {31'b0, mem_ready}, 32'd0);
      next_cycle();
    end
    cur = 1020;
    @(negedge clk);
    check("rst_seq done ready", {31'b0, mem_ready}, 32'd1);
    check("rst_seq done we_n",  {31'b0, sram_we_n}, 32'd1);
    next_cycle();
    mem_wr_en = 0;
    @(negedge clk); check("rst_seq after ready", {31'b0, mem_ready}, 32'd0);
    next_cycle();

    // WAIT_CYCLES=1: ready two cycles after the request
    cur = 2000;
    b_mem_rd_en = 1; b_mem_addr = 32'h40;
    @(negedge clk);
    check("w1 load t0 ready", {31'b0, b_mem_ready}, 32'd0);
    check("w1 load t0 stall", {31'b0, b_mem_stall}, 32'd1);
    next_cycle();
    @(negedge clk);
    check("w1 load t1 ready", {31'b0, b_mem_ready}, 32'd0);
    check("w1 load t1 state", {30'b0, b_dbg_state}, 32'd1);
    next_cycle();
    @(negedge clk);
    check("w1 load t2 ready", {31'b0, b_mem_ready}, 32'd1);
    check("w1 load rdata",    b_mem_rdata, 32'h13579BDF);
    next_cycle();
    b_mem_rd_en = 0;
    @(negedge clk); check("w1 idle state", {30'b0, b_dbg_state}, 32'd0);
    next_cycle();
    cur = 2010;
    b_mem_wr_en = 1; b_mem_addr = 32'h4; b_mem_wdata = 32'hA5;
    @(negedge clk); check("w1 store t0 we_n", {31'b0, b_sram_we_n}, 32'd1);
    next_cycle();
    @(negedge clk);
    check("w1 store t1 we_n", {31'b0, b_sram_we_n}, 32'd0);
    check("w1 store t1 addr", {15'b0, b_sram_addr}, 32'h1);
    next_cycle();
    @(negedge clk);
    check("w1 store t2 ready", {31'b0, b_mem_ready}, 32'd1);
    check("w1 store rdata",    b_mem_rdata, 32'h13579BDF);
    check("w1 store sram",     mem1[1], 32'hA5);
    next_cycle();
    b_mem_wr_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
